// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus.
// The access unit is the master; the memory is the slave.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data access: sizing, lane steering,
// req/ack handshake with wait states and timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic        write_back_in,
  input  logic [4:0]  read_rd_in,
  input  logic [31:0] data_address_in,
  input  logic [31:0] store_data_in,
  mem_access_unit_if.master dmem,
  output logic        write_back_out,
  output logic [4:0]  read_rd_out,
  output logic [31:0] data_address_out,
  output logic [31:0] data_mem_out,
  output logic        stall_out,
  output logic        access_fault_out,
  output logic        bus_error_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        wb;
  } req_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  req_t            held, cur, sel;
  logic            latch;
  logic            is_mem;
  logic            bad;
  logic            req;
  logic            wb;
  logic [4:0]      rd;
  logic [31:0]     addr;
  logic [31:0]     mdata;
  logic            stall;
  logic            fault;
  logic            berr;

  function automatic logic legal_f3(
    input logic [2:0] f3
  );
    unique case (f3)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    unique case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return a != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] steer_data(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    unique case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] steer_be(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    unique case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract(
    input logic [2:0]  f3,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    unique case (a)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    unique case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  // Build the request implied by the EX/MEM slot.
  always_comb begin
    cur.addr   = data_address_in;
    cur.wdata  = steer_data(funct3_in,
                            store_data_in);
    cur.be     = mem_write_in
               ? steer_be(funct3_in,
                          data_address_in[1:0])
               : 4'b1111;
    cur.we     = mem_write_in;
    cur.funct3 = funct3_in;
    cur.rd     = read_rd_in;
    cur.wb     = write_back_in & mem_read_in;
    is_mem     = valid_in
               & (mem_read_in | mem_write_in);
    bad        = ~legal_f3(funct3_in)
               | misaligned(funct3_in,
                            data_address_in[1:0]);
  end

  // Next state, handshake and MEM/WB outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    sel       = cur;
    req       = 1'b0;
    wb        = 1'b0;
    rd        = read_rd_in;
    addr      = data_address_in;
    mdata     = '0;
    stall     = 1'b0;
    fault     = 1'b0;
    berr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!is_mem) begin
          wb = valid_in & write_back_in;
        end else if (bad) begin
          fault = 1'b1;
        end else begin
          req = 1'b1;
          if (dmem.dmem_ack) begin
            wb = cur.wb;
            if (!cur.we)
              mdata = extract(cur.funct3,
                              cur.addr[1:0],
                              dmem.dmem_rdata);
          end else begin
            latch     = 1'b1;
            stall     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        sel     = held;
        req     = 1'b1;
        rd      = held.rd;
        addr    = held.addr;
        cnt_nxt = cnt + 1'b1;
        if (dmem.dmem_ack) begin
          wb        = held.wb;
          if (!held.we)
            mdata = extract(held.funct3,
                            held.addr[1:0],
                            dmem.dmem_rdata);
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          berr      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reset silences every output, abandoning any access.
  always_comb begin
    dmem.dmem_req    = req & ~reset;
    dmem.dmem_we     = sel.we & req & ~reset;
    dmem.dmem_addr   = reset ? '0
                     : {sel.addr[31:2], 2'b00};
    dmem.dmem_be     = reset ? '0 : sel.be;
    dmem.dmem_wdata  = reset ? '0 : sel.wdata;
    write_back_out   = wb & ~reset;
    read_rd_out      = reset ? '0 : rd;
    data_address_out = reset ? '0 : addr;
    data_mem_out     = reset ? '0 : mdata;
    stall_out        = stall & ~reset;
    access_fault_out = fault & ~reset;
    bus_error_out    = berr & ~reset;
  end

  // State, wait counter and latched request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      held  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch)
        held <= cur;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed checks of the MEM-stage access unit
// with a hand-driven memory responder.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic        write_back_in;
  logic [4:0]  read_rd_in;
  logic [31:0] data_address_in;
  logic [31:0] store_data_in;
  logic        write_back_out;
  logic [4:0]  read_rd_out;
  logic [31:0] data_address_out;
  logic [31:0] data_mem_out;
  logic        stall_out;
  logic        access_fault_out;
  logic        bus_error_out;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .valid_in         (valid_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .funct3_in        (funct3_in),
    .write_back_in    (write_back_in),
    .read_rd_in       (read_rd_in),
    .data_address_in  (data_address_in),
    .store_data_in    (store_data_in),
    .dmem             (bus),
    .write_back_out   (write_back_out),
    .read_rd_out      (read_rd_out),
    .data_address_out (data_address_out),
    .data_mem_out     (data_mem_out),
    .stall_out        (stall_out),
    .access_fault_out (access_fault_out),
    .bus_error_out    (bus_error_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Drive a slot at the falling edge, then
  // let the combinational outputs settle.
  task automatic op(
    input logic        v,
    input logic        rd_en,
    input logic        wr_en,
    input logic [2:0]  f3,
    input logic        wbk,
    input logic [4:0]  rdn,
    input logic [31:0] a,
    input logic [31:0] sd,
    input logic        ack,
    input logic [31:0] rdat
  );
    @(negedge clock);
    valid_in        = v;
    mem_read_in     = rd_en;
    mem_write_in    = wr_en;
    funct3_in       = f3;
    write_back_in   = wbk;
    read_rd_in      = rdn;
    data_address_in = a;
    store_data_in   = sd;
    bus.dmem_ack    = ack;
    bus.dmem_rdata  = rdat;
    #1;
  endtask

  task automatic idle_slot();
    op(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  int stalls;

  initial begin
    reset = 1'b1;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    // Reset held while a load is presented
    op(1, 1, 0, 3'b010, 1, 5'd3,
       32'h100, 0, 1, 32'h1111_1111);
    chk("rst_req",   bus.dmem_req, 0);
    chk("rst_wb",    write_back_out, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_dmem",  data_mem_out, 0);
    chk("rst_fault", access_fault_out, 0);

    // Release: same load issues at once
    @(negedge clock);
    reset = 1'b0;
    op(1, 1, 0, 3'b010, 1, 5'd3,
       32'h100, 0, 0, 0);
    chk("rel_req",   bus.dmem_req, 1);
    chk("rel_stall", stall_out, 1);
    chk("rel_wb",    write_back_out, 0);
    op(1, 1, 0, 3'b010, 1, 5'd3,
       32'h100, 0, 1, 32'h1122_3344);
    chk("rel_done",  data_mem_out,
        32'h1122_3344);
    chk("rel_wb2",   write_back_out, 1);
    chk("rel_rd",    read_rd_out, 3);

    // Non-memory pass-through
    op(1, 0, 0, 3'b000, 1, 5'd7,
       32'h1234, 0, 0, 0);
    chk("pt_wb",   write_back_out, 1);
    chk("pt_rd",   read_rd_out, 7);
    chk("pt_addr", data_address_out, 32'h1234);
    chk("pt_req",  bus.dmem_req, 0);
    chk("pt_dmem", data_mem_out, 0);

    // Zero-wait byte/half loads
    op(1, 1, 0, 3'b000, 1, 5'd9,
       32'h103, 0, 1, 32'h80AA_BBCC);
    chk("lb_addr",  bus.dmem_addr, 32'h100);
    chk("lb_data",  data_mem_out, 32'hFFFF_FF80);
    chk("lb_wb",    write_back_out, 1);
    chk("lb_stall", stall_out, 0);
    chk("lb_be",    bus.dmem_be, 4'b1111);
    op(1, 1, 0, 3'b100, 1, 5'd9,
       32'h103, 0, 1, 32'h80AA_BBCC);
    chk("lbu_data", data_mem_out, 32'h0000_0080);
    op(1, 1, 0, 3'b001, 1, 5'd9,
       32'h102, 0, 1, 32'h80AA_BBCC);
    chk("lh_data",  data_mem_out, 32'hFFFF_80AA);
    op(1, 1, 0, 3'b101, 1, 5'd9,
       32'h100, 0, 1, 32'h80AA_BBCC);
    chk("lhu_data", data_mem_out, 32'h0000_BBCC);

    // Zero-wait store byte
    op(1, 0, 1, 3'b000, 0, 0,
       32'h001, 32'hFFFF_FF55, 1, 0);
    chk("sb_be",    bus.dmem_be, 4'b0010);
    chk("sb_wdata", bus.dmem_wdata, 32'h5555_5555);
    chk("sb_we",    bus.dmem_we, 1);
    chk("sb_wb",    write_back_out, 0);

    // Store half with three wait cycles
    stalls = 0;
    op(1, 0, 1, 3'b001, 0, 0,
       32'h202, 32'h1234_ABCD, 0, 0);
    chk("sh_be",    bus.dmem_be, 4'b1100);
    chk("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
    chk("sh_addr",  bus.dmem_addr, 32'h200);
    if (stall_out) stalls++;
    for (int i = 1; i <= 3; i++) begin
      op(1, 0, 1, 3'b001, 0, 0,
         32'hDEAD_0000, 32'h0, (i == 3), 0);
      chk("sh_hold_req", bus.dmem_req, 1);
      chk("sh_hold_addr", bus.dmem_addr, 32'h200);
      chk("sh_hold_be", bus.dmem_be, 4'b1100);
      if (stall_out) stalls++;
    end
    chk("sh_stalls", stalls, 3);
    chk("sh_wb",     write_back_out, 0);
    idle_slot();
    chk("sh_after",  bus.dmem_req, 0);

    // Access faults
    op(1, 1, 0, 3'b010, 1, 5'd4,
       32'h301, 0, 0, 0);
    chk("lw_mis_flt", access_fault_out, 1);
    chk("lw_mis_req", bus.dmem_req, 0);
    chk("lw_mis_wb",  write_back_out, 0);
    chk("lw_mis_stl", stall_out, 0);
    op(1, 1, 0, 3'b011, 1, 5'd4,
       32'h300, 0, 0, 0);
    chk("f3_flt", access_fault_out, 1);
    chk("f3_req", bus.dmem_req, 0);
    op(1, 1, 0, 3'b001, 1, 5'd4,
       32'h303, 0, 0, 0);
    chk("lh_mis_flt", access_fault_out, 1);
    idle_slot();
    chk("flt_pulse", access_fault_out, 0);

    // Timeout: no ack for four WAIT cycles
    op(1, 1, 0, 3'b010, 1, 5'd6,
       32'h400, 0, 0, 0);
    chk("to_issue", stall_out, 1);
    for (int i = 1; i <= 3; i++) begin
      op(1, 1, 0, 3'b010, 1, 5'd6,
         32'h400, 0, 0, 0);
      chk("to_wait_stl", stall_out, 1);
      chk("to_wait_err", bus_error_out, 0);
    end
    op(1, 1, 0, 3'b010, 1, 5'd6,
       32'h400, 0, 0, 0);
    chk("to_err",   bus_error_out, 1);
    chk("to_stall", stall_out, 0);
    chk("to_wb",    write_back_out, 0);
    chk("to_req",   bus.dmem_req, 1);
    idle_slot();
    chk("to_drop",  bus.dmem_req, 0);
    chk("to_pulse", bus_error_out, 0);

    // Ack on the last WAIT cycle wins
    op(1, 1, 0, 3'b010, 1, 5'd8,
       32'h404, 0, 0, 0);
    for (int i = 1; i <= 3; i++)
      op(1, 1, 0, 3'b010, 1, 5'd8,
         32'h404, 0, 0, 0);
    op(1, 1, 0, 3'b010, 1, 5'd8,
       32'h404, 0, 1, 32'hCAFE_F00D);
    chk("late_err",  bus_error_out, 0);
    chk("late_wb",   write_back_out, 1);
    chk("late_data", data_mem_out, 32'hCAFE_F00D);
    chk("late_rd",   read_rd_out, 8);

    // Reset two cycles into WAIT
    op(1, 1, 0, 3'b010, 1, 5'd2,
       32'h500, 0, 0, 0);
    op(1, 1, 0, 3'b010, 1, 5'd2,
       32'h500, 0, 0, 0);
    op(1, 1, 0, 3'b010, 1, 5'd2,
       32'h500, 0, 1, 32'h7777_7777);
    reset = 1'b1;
    #1;
    chk("rw_req",   bus.dmem_req, 0);
    chk("rw_wb",    write_back_out, 0);
    chk("rw_stall", stall_out, 0);
    @(negedge clock);
    reset = 1'b0;
    idle_slot();
    chk("rw_idle_req", bus.dmem_req, 0);
    chk("rw_idle_stl", stall_out, 0);
    chk("rw_idle_wb",  write_back_out, 0);
    chk("rw_idle_err", bus_error_out, 0);
    op(1, 1, 0, 3'b100, 1, 5'd1,
       32'h501, 0, 1, 32'h0000_AB00);
    chk("rw_next_data", data_mem_out, 32'h0000_00AB);
    chk("rw_next_wb",   write_back_out, 1);
    chk("rw_next_stl",  stall_out, 0);
    idle_slot();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the five-stage RISC-V core, directly upstream of the MEM/WB pipeline register. It takes the EX/MEM operation, performs RV32I load/store sizing, alignment and byte-lane steering, and runs a req/ack handshake with data memory with wait-state support and a timeout. It presents the result (`write_back_out`, `data_mem_out`, `read_rd_out`, `data_address_out`) to MEM/WB and stalls the upstream pipeline while an access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 16: number of WAIT cycles without `dmem_ack` before a bus error is raised (≥1).
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_in` in 1: EX/MEM slot holds a real instruction.
- `mem_read_in`, `mem_write_in` in 1: load / store (never both).
- `funct3_in` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `write_back_in` in 1: instruction writes rd.
- `read_rd_in` in 5: destination register.
- `data_address_in` in 32: ALU result / effective address.
- `store_data_in` in 32: rs2 value.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_be` out 4, `dmem_wdata` out 32: memory request.
- `dmem_ack` in 1, `dmem_rdata` in 32: completion; rdata valid with ack.
- `write_back_out` out 1, `read_rd_out` out 5, `data_address_out` out 32, `data_mem_out` out 32: to MEM/WB.
- `stall_out` out 1: hold IF..EX/MEM this cycle.
- `access_fault_out` out 1: misaligned or unsupported funct3 (1-cycle pulse).
- `bus_error_out` out 1: timeout (1-cycle pulse).

## Operation
- FSM: IDLE, WAIT. Registered: state, WAIT counter, latched request (address, wdata, be, we, funct3, rd, write_back).
- Non-memory op (IDLE): pass-through; `write_back_out = valid_in & write_back_in`, `data_mem_out = 0`, no stall.
- Fault check (IDLE, valid mem op): H/HU with addr[0]=1, W with addr[1:0]≠0, or funct3 ∉ {000,001,010,100,101} → `access_fault_out=1`, no request, `write_back_out=0`, no stall.
- Memory op (IDLE, legal): `dmem_req=1`; ack same cycle → complete, stay IDLE; else latch request, go WAIT, `stall_out=1`.
- WAIT: drive latched request with `dmem_req=1`, counter++. Ack → complete, `stall_out=0`, IDLE, counter=0. No ack on the `TIMEOUT_CYCLES`-th WAIT cycle → `bus_error_out=1`, `write_back_out=0`, `stall_out=0`, `dmem_req` dropped next cycle, IDLE. Ack in that same cycle wins (normal completion).
- While stalled, `write_back_out=0` (bubble into MEM/WB).
- Address: `dmem_addr = {addr[31:2],2'b00}`.
- Store steering: SB `wdata={4{d[7:0]}}`, `be=4'b0001<<addr[1:0]`; SH `wdata={2{d[15:0]}}`, `be=4'b0011<<{addr[1],1'b0}`; SW `wdata=d`, `be=4'b1111`. Loads: `dmem_we=0`, `be=4'b1111`.
- Load extract on ack: select byte `addr[1:0]` / half `addr[1]` / word; B,H sign-extend; BU,HU zero-extend → `data_mem_out`.
- Completion: `write_back_out = write_back` (stores: 0), `read_rd_out`, `data_address_out` from current (IDLE) or latched (WAIT) values.

## Timing
- Reset: state IDLE, counter 0, latched regs 0; while `reset`=1 all outputs forced 0 (`dmem_req`, `stall_out`, `write_back_out`, pulses). Reset in WAIT abandons the access; no completion or error reported.
- Zero-wait access: request and completion in the same cycle, no stall.
- N-wait access (ack N cycles after issue, N ≤ TIMEOUT_CYCLES): `stall_out` high N cycles, completion on ack cycle.
- `dmem_req` and request fields stable from issue until ack/timeout cycle inclusive.
- Faults/pass-through: combinational, 0 extra cycles.

## Test plan
- Reset with `valid_in`=1 load → all outputs 0; release → IDLE, next cycle issues request.
- LB addr 0x103, ack same cycle, rdata 0x80AA_BBCC → `dmem_addr`=0x100, `data_mem_out`=0xFFFF_FF80, `write_back_out`=1, no stall; LBU same → 0x0000_0080.
- SH addr 0x202, data 0x1234_ABCD, ack after 3 cycles → `be`=1100, `wdata`=0xABCD_ABCD, `stall_out` high 3 cycles, `write_back_out`=0.
- LW addr 0x301 → `access_fault_out`=1 one cycle, `dmem_req`=0; funct3=011 load → same.
- TIMEOUT_CYCLES=4, no ack → `bus_error_out` on 4th WAIT cycle, `dmem_req` low next cycle; ack on 4th cycle → normal completion, no error.
- Reset asserted 2 cycles into WAIT → `dmem_req`/`stall_out` 0 next edge, no `write_back_out`, following op issues cleanly.
